// File: rtl/cache_req_queue.sv
// cache_req_queue: address FIFO feeding the cache controller's index/tag port with an in-flight lookup throttle
// Ports: clk_i/rst_i clock and sync reset; req_addr_i/req_valid_i/req_ready_o requester handshake;
// index_o/tag_o/it_valid_o/it_ready_i controller lookup handshake; hm_valid_i/hm_ready_i observed result
// handshake; count_o FIFO occupancy; inflight_o outstanding lookups.
module cache_req_queue #(
    parameter int index_width  = 10,
    parameter int tag_width    = 16,
    parameter int offset_width = 4,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [tag_width+index_width+offset_width-1:0] req_addr_i,
    input  logic                                          req_valid_i,
    output logic                                          req_ready_o,
    output logic [index_width-1:0]                        index_o,
    output logic [tag_width-1:0]                          tag_o,
    output logic                                          it_valid_o,
    input  logic                                          it_ready_i,
    input  logic                                          hm_valid_i,
    input  logic                                          hm_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]                    count_o,
    output logic [1:0]                                    inflight_o
);
    localparam int EW = tag_width + index_width;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic push, pop, retire;
    assign req_ready_o = count_o != CW'(DEPTH);
    assign it_valid_o  = (count_o != '0) && (inflight_o < 2'(MAX_INFLIGHT));
    assign push        = req_valid_i && req_ready_o;
    assign pop         = it_valid_o && it_ready_i;
    // a result seen with nothing outstanding belongs to a lookup discarded by reset
    assign retire      = hm_valid_i && hm_ready_i && (inflight_o != '0);
    assign {tag_o, index_o} = mem[rd_ptr];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            inflight_o <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= req_addr_i[offset_width +: EW];
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count_o    <= count_o + CW'(push) - CW'(pop);
            inflight_o <= inflight_o + 2'(pop) - 2'(retire);
        end
    end
    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i) count_o <= CW'(DEPTH));
    a_inflight_max: assert property (@(posedge clk_i) disable iff (rst_i) inflight_o <= 2'(MAX_INFLIGHT));
    a_it_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        it_valid_o && !it_ready_i |=> it_valid_o && $stable({index_o, tag_o}));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push |-> count_o != CW'(DEPTH));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> count_o != '0);
    a_no_idle_retire: assert property (@(posedge clk_i) disable iff (rst_i)
        hm_valid_i && hm_ready_i |-> inflight_o != '0);
    c_full: cover property (@(posedge clk_i) disable iff (rst_i) count_o == CW'(DEPTH));
    c_empty: cover property (@(posedge clk_i) disable iff (rst_i) count_o == '0);
    c_wrap: cover property (@(posedge clk_i) disable iff (rst_i) push && wr_ptr == PW'(DEPTH - 1));
    c_push_pop: cover property (@(posedge clk_i) disable iff (rst_i) push && pop);
    c_throttle: cover property (@(posedge clk_i) disable iff (rst_i)
        count_o != '0 && inflight_o >= 2'(MAX_INFLIGHT));
endmodule

// File: tb/tb_cache_req_queue.sv
// tb_cache_req_queue: table, directed and randomized checks of cache_req_queue against a queue model
module tb_cache_req_queue;
    localparam int DEPTH = 4;
    localparam int MAXI  = 1;
    typedef struct {
        logic        rv;
        logic [29:0] addr;
        logic        itr, hmv, hmr;
        logic        rdy, vld;
        logic [2:0]  cnt;
        logic [1:0]  inf;
        logic [15:0] tag;
        logic [9:0]  idx;
    } vec_t;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [29:0] req_addr_i = '0;
    logic        req_valid_i = 1'b0, it_ready_i = 1'b0, hm_valid_i = 1'b0, hm_ready_i = 1'b0;
    logic        req_ready_o, it_valid_o;
    logic [9:0]  index_o;
    logic [15:0] tag_o;
    logic [2:0]  count_o;
    logic [1:0]  inflight_o;
    int checks = 0, errors = 0;
    logic [25:0] mq[$];
    int infl = 0;
    bit last_push, last_ret;
    always #5 clk_i = ~clk_i;
    cache_req_queue dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_addr_i(req_addr_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .index_o(index_o), .tag_o(tag_o), .it_valid_o(it_valid_o),
        .it_ready_i(it_ready_i), .hm_valid_i(hm_valid_i), .hm_ready_i(hm_ready_i),
        .count_o(count_o), .inflight_o(inflight_o)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic rv, input logic [29:0] a, input logic itr, input logic hmv, input logic hmr);
        req_valid_i = rv;
        req_addr_i  = a;
        it_ready_i  = itr;
        hm_valid_i  = hmv;
        hm_ready_i  = hmr;
    endtask
    task automatic step();
        bit m_pop;
        last_push = req_valid_i && mq.size() != DEPTH;
        m_pop     = it_ready_i && mq.size() != 0 && infl < MAXI;
        last_ret  = hm_valid_i && hm_ready_i && infl > 0;
        @(posedge clk_i);
        if (rst_i) begin
            mq.delete();
            infl = 0;
        end else begin
            if (m_pop) begin
                void'(mq.pop_front());
                infl++;
            end
            if (last_push) mq.push_back(req_addr_i[29:4]);
            if (last_ret) infl--;
        end
        #1;
    endtask
    task automatic check_model(input string nm);
        chk({nm, " ready"}, 32'(req_ready_o), 32'(mq.size() != DEPTH));
        chk({nm, " it_valid"}, 32'(it_valid_o), 32'(mq.size() != 0 && infl < MAXI));
        chk({nm, " count"}, 32'(count_o), 32'(mq.size()));
        chk({nm, " inflight"}, 32'(inflight_o), 32'(infl));
        if (mq.size() != 0) begin
            chk({nm, " tag"}, 32'(tag_o), 32'(mq[0][25:10]));
            chk({nm, " index"}, 32'(index_o), 32'(mq[0][9:0]));
        end
    endtask
    initial begin
        vec_t tbl[15];
        logic [29:0] a_a, a_b, a_c, a_d, a_e, a_f;
        a_a = 30'h0ABCDEF5;
        a_b = {16'h1111, 10'h011, 4'h1};
        a_c = {16'h2222, 10'h022, 4'h2};
        a_d = {16'h3333, 10'h033, 4'h3};
        a_e = {16'h4444, 10'h044, 4'h4};
        a_f = {16'h5555, 10'h055, 4'h5};
        tbl[0]  = '{1'b1, a_a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 2'd1 - 2'd1, 16'h2AF3, 10'h1EF};
        tbl[1]  = '{1'b0, '0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 16'h0, 10'h0};
        tbl[2]  = '{1'b0, '0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 16'h0, 10'h0};
        tbl[3]  = '{1'b0, '0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 16'h0, 10'h0};
        tbl[4]  = '{1'b0, '0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0, 10'h0};
        tbl[5]  = '{1'b1, a_b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 2'd0, 16'h1111, 10'h011};
        tbl[6]  = '{1'b1, a_c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 2'd0, 16'h1111, 10'h011};
        tbl[7]  = '{1'b1, a_d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 2'd0, 16'h1111, 10'h011};
        tbl[8]  = '{1'b1, a_e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'd0, 16'h1111, 10'h011};
        tbl[9]  = '{1'b1, a_f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'd0, 16'h1111, 10'h011};
        tbl[10] = '{1'b1, a_f, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 2'd1, 16'h2222, 10'h022};
        tbl[11] = '{1'b1, a_f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'd1, 16'h2222, 10'h022};
        tbl[12] = '{1'b0, '0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 2'd0, 16'h2222, 10'h022};
        tbl[13] = '{1'b0, '0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 2'd1, 16'h3333, 10'h033};
        tbl[14] = '{1'b0, '0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 2'd0, 16'h3333, 10'h033};
        step();
        step();
        rst_i = 1'b0;
        chk("reset ready", 32'(req_ready_o), 32'd1);
        chk("reset it_valid", 32'(it_valid_o), 32'd0);
        chk("reset count", 32'(count_o), 32'd0);
        chk("reset inflight", 32'(inflight_o), 32'd0);
        chk("reset tag", 32'(tag_o), 32'd0);
        chk("reset index", 32'(index_o), 32'd0);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rv, tbl[i].addr, tbl[i].itr, tbl[i].hmv, tbl[i].hmr);
            step();
            chk($sformatf("vec%0d ready", i), 32'(req_ready_o), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d it_valid", i), 32'(it_valid_o), 32'(tbl[i].vld));
            chk($sformatf("vec%0d count", i), 32'(count_o), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d inflight", i), 32'(inflight_o), 32'(tbl[i].inf));
            if (tbl[i].cnt != 0) begin
                chk($sformatf("vec%0d tag", i), 32'(tag_o), 32'(tbl[i].tag));
                chk($sformatf("vec%0d index", i), 32'(index_o), 32'(tbl[i].idx));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 30'($urandom), 1'b0, 1'b0, 1'b0);
            step();
            check_model("prefill");
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 30'($urandom), 1'b1, 1'b0, 1'b0);
            step();
            chk("pushpop count", 32'(count_o), 32'd2);
            chk("pushpop inflight", 32'(inflight_o), 32'd1);
            check_model("pushpop");
            drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
            step();
            chk("retire count", 32'(count_o), 32'd2);
            check_model("retire");
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        drive(1'b1, 30'($urandom), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 30'($urandom), 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 30'($urandom), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 30'($urandom), 1'b0, 1'b0, 1'b0);
        step();
        chk("midflight count", 32'(count_o), 32'd3);
        chk("midflight inflight", 32'(inflight_o), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midreset count", 32'(count_o), 32'd0);
        chk("midreset inflight", 32'(inflight_o), 32'd0);
        chk("midreset it_valid", 32'(it_valid_o), 32'd0);
        chk("midreset ready", 32'(req_ready_o), 32'd1);
        chk("midreset tag", 32'(tag_o), 32'd0);
        chk("midreset index", 32'(index_o), 32'd0);
        for (int c = 0; c < 800; c++) begin
            it_ready_i = $urandom_range(0, 1) == 1;
            hm_ready_i = $urandom_range(0, 2) != 0;
            step();
            check_model("rand");
            chk("rand inflight bound", 32'(inflight_o <= 2'(MAXI)), 32'd1);
            if (last_ret) hm_valid_i = 1'b0;
            if (!hm_valid_i && infl > 0 && $urandom_range(0, 2) == 0) hm_valid_i = 1'b1;
            if (!req_valid_i || last_push) begin
                req_valid_i = $urandom_range(0, 1) == 1;
                req_addr_i  = 30'($urandom);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
